// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the pipelined MIPS core hazard logic.
package mips_pipe_pkg;

   localparam int REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_e;

endpackage

// File: rtl/load_use_cmp.sv
// Combinational load-use hazard compare between the EX load and the ID sources.
module load_use_cmp
   import mips_pipe_pkg::*;
(
   input  logic [REG_IDX_W-1:0] id_rs,
   input  logic [REG_IDX_W-1:0] id_rt,
   input  logic                 id_uses_rt,
   input  logic                 ex_mem_read,
   input  logic [REG_IDX_W-1:0] ex_rt,
   output logic                 lu_hit
);

   // $zero never carries a real dependency.
   assign lu_hit = ex_mem_read && (ex_rt != REG_ZERO) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hold/flush sequencer: load-use bubbles, branch flushes and memory-wait freezes.
//   state    | meaning
//   RUN      | normal issue; hazards evaluated from current inputs
//   LU_STALL | extra load-use bubbles still being inserted
//   MEM_WAIT | full freeze until both memories are ready
module hazard_stall_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int LU_BUBBLES = 1,
   parameter int TIMEOUT    = 255,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] id_rs,
   input  logic [REG_IDX_W-1:0] id_rt,
   input  logic                 id_uses_rt,
   input  logic                 ex_mem_read,
   input  logic [REG_IDX_W-1:0] ex_rt,
   input  logic                 branch_taken,
   input  logic                 imem_ready,
   input  logic                 dmem_busy,
   output logic                 pc_stall,
   output logic                 ifid_stall,
   output logic                 ifid_flush,
   output logic                 idex_stall,
   output logic                 idex_flush,
   output logic                 exmem_stall,
   output logic                 mem_timeout,
   output logic [CNT_W-1:0]     stall_cycles
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
   localparam logic [1:0] BUB_LOAD = 2'(LU_BUBBLES - 1);

   hz_state_e          state_q, state_d;
   logic [1:0]         bub_q, bub_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               flush_pend_q, flush_pend_d;
   logic               mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

   logic lu_hit, mem_wait, run_eval;
   logic do_freeze, do_flush, do_lu;

   load_use_cmp u_lu_cmp (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .lu_hit      (lu_hit)
   );

   assign mem_wait = ~imem_ready | dmem_busy;

   always_comb begin
      state_d      = state_q;
      bub_d        = bub_q;
      flush_pend_d = flush_pend_q;
      do_freeze    = 1'b0;
      do_flush     = 1'b0;
      do_lu        = 1'b0;
      run_eval     = 1'b0;

      case (state_q)
         RUN: run_eval = 1'b1;
         LU_STALL: begin
            if (mem_wait) begin
               do_freeze = 1'b1;
               bub_d     = 2'd0;
               state_d   = MEM_WAIT;
            end else begin
               do_lu = 1'b1;
               if (bub_q <= 2'd1) begin
                  bub_d   = 2'd0;
                  state_d = RUN;
               end else begin
                  bub_d = bub_q - 2'd1;
               end
            end
         end
         MEM_WAIT: begin
            // EX is held during the freeze, so new branch_taken pulses are stale.
            if (mem_wait) begin
               do_freeze = 1'b1;
            end else if (flush_pend_q) begin
               do_flush     = 1'b1;
               flush_pend_d = 1'b0;
               state_d      = RUN;
            end else begin
               state_d  = RUN;
               run_eval = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase

      if (run_eval) begin
         if (mem_wait) begin
            do_freeze    = 1'b1;
            flush_pend_d = branch_taken;
            state_d      = MEM_WAIT;
         end else if (branch_taken) begin
            do_flush = 1'b1;
         end else if (lu_hit) begin
            do_lu = 1'b1;
            if (LU_BUBBLES > 1) begin
               bub_d   = BUB_LOAD;
               state_d = LU_STALL;
            end
         end
      end
   end

   assign pc_stall    = reset & (do_freeze | do_lu);
   assign ifid_stall  = reset & (do_freeze | do_lu);
   assign ifid_flush  = reset & do_flush;
   assign idex_stall  = reset & do_freeze;
   assign idex_flush  = reset & (do_flush | do_lu);
   assign exmem_stall = reset & do_freeze;

   always_comb begin
      wait_d = '0;
      if (do_freeze) begin
         wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
      end
      mem_timeout_d  = mem_timeout_q | (do_freeze && (wait_d == WAIT_MAX));
      stall_cycles_d = stall_cycles_q;
      if (pc_stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= RUN;
         bub_q          <= 2'd0;
         wait_q         <= '0;
         flush_pend_q   <= 1'b0;
         mem_timeout_q  <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         bub_q          <= bub_d;
         wait_q         <= wait_d;
         flush_pend_q   <= flush_pend_d;
         mem_timeout_q  <= mem_timeout_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Drives the pipeline's hold/flush controls: the PC's active-low update enable (pc_stall, 1 = hold PC), plus IF/ID, ID/EX and EX/MEM stall and flush lines.
- Detects load-use hazards, taken branches/jumps and memory-wait conditions.
- Sequences multi-cycle freezes and deferred flushes with a small FSM.
- Sits beside the ID stage; its outputs feed the PC and pipeline registers of the pipelined MIPS core.

Parameters:
LU_BUBBLES, 1, load-use bubble cycles inserted (1..3)
TIMEOUT, 255, max consecutive memory-wait cycles before mem_timeout is flagged
CNT_W, 16, width of stall_cycles performance counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (sampled only on posedge clk)
id_rs  in  5  rs of instruction in ID
id_rt  in  5  rt of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  5  destination rt of the EX load
branch_taken  in  1  branch/jump resolved taken in EX this cycle
imem_ready  in  1  instruction memory has valid data
dmem_busy  in  1  data memory not yet complete
pc_stall  out  1  1 = PC holds (drives the PC enable directly)
ifid_stall  out  1  IF/ID holds
ifid_flush  out  1  IF/ID loads NOP
idex_stall  out  1  ID/EX holds
idex_flush  out  1  ID/EX loads NOP (bubble)
exmem_stall  out  1  EX/MEM holds
mem_timeout  out  1  sticky error flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Reset (reset=0 at posedge): state=RUN, bubble counter=0, wait counter=0, flush_pend=0, mem_timeout=0, stall_cycles=0.
- While reset is low, all stall/flush outputs are forced 0.
- Stall/flush outputs are combinational from state plus current inputs, with zero-cycle latency; all state is registered.
- lu_hit = ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt)).
- mem_wait = ~imem_ready | dmem_busy.
- Priority each cycle: mem_wait > branch_taken > lu_hit.
- States:
  RUN:
  - mem_wait: freeze (pc_stall, ifid_stall, idex_stall, exmem_stall = 1), no flushes, go to MEM_WAIT. If branch_taken in the same cycle, set flush_pend=1.
  - else branch_taken: ifid_flush=1, idex_flush=1, pc_stall=0. Stay in RUN. A simultaneous lu_hit is ignored because the ID instruction is being flushed.
  - else lu_hit: pc_stall=1, ifid_stall=1, idex_flush=1. If LU_BUBBLES>1, load bubble counter=LU_BUBBLES-1 and go to LU_STALL.
  LU_STALL:
  - Outputs identical to the lu_hit case.
  - Counter decrements; at 1, return to RUN.
  - mem_wait preempts: go to MEM_WAIT and discard the remaining bubbles. The hazard is re-detected in RUN if still present.
  MEM_WAIT:
  - Full freeze while mem_wait; wait counter increments.
  - When the counter reaches TIMEOUT, set mem_timeout=1 (sticky until reset) and keep waiting.
  - When mem_wait=0, counter clears and state goes to RUN.
  - If flush_pend is set on exit, that same exit cycle asserts ifid_flush and idex_flush, then clears flush_pend. Any branch_taken arriving during the freeze is ignored: EX is held, so the original branch is already recorded.
- stall_cycles increments on every cycle with pc_stall=1 and saturates at all-ones. It does not wrap.
- Reset asserted mid-stall: next cycle is RUN, all counters and flags cleared, and no pending flush is preserved.
- Outputs never assert a stall and a flush on the same register in the same cycle.

Decomposition:
- Shared package mips_pipe_pkg:
  - state encoding (RUN, LU_STALL, MEM_WAIT)
  - REG_ZERO = 5'd0
  - register-index width constant
- One natural sub-module: load_use_cmp, a combinational lu_hit compare. It is reusable by the forwarding unit.

Test Plan:
1. ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle, LU_BUBBLES=1 -> exactly one cycle with pc_stall=1, ifid_stall=1, idex_flush=1; stall_cycles=1.
2. Same hazard with ex_rt=0 -> no stall. With id_rt=8 and id_uses_rt=0 -> no stall. With id_uses_rt=1 -> one stall cycle.
3. branch_taken=1 together with lu_hit -> ifid_flush=1, idex_flush=1, pc_stall=0 for one cycle.
4. dmem_busy=1 for 5 cycles, with branch_taken=1 on the first of them -> 5 cycles of full freeze, then 1 cycle of ifid_flush/idex_flush; stall_cycles=5.
5. TIMEOUT=4, imem_ready=0 for 10 cycles -> mem_timeout rises after the 4th wait cycle and stays 1 until reset. Freeze lasts all 10 cycles.
6. reset=0 during the 2nd cycle of a LU_BUBBLES=3 stall -> next cycle all outputs 0 and stall_cycles=0. After release, state is RUN with no residual bubbles.
